// File: rtl/if_stage.sv
// Instruction fetch stage: owns the PC, issues one outstanding request at a
// time to instruction memory, and delivers one instruction per cycle into the
// decode slot. A one-entry hold buffer absorbs decode stalls, and a KILL state
// swallows the response of a request abandoned by a branch redirect.
`timescale 1ns/1ps
module if_stage #(
    parameter int unsigned       ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ready,
    input  logic [31:0]       imem_rdata,
    input  logic              stall,
    input  logic              branch_taken,
    input  logic [ADDR_W-1:0] branch_target,
    output logic              if_valid,
    output logic [31:0]       if_instr,
    output logic [ADDR_W-1:0] if_pc,
    output logic [ADDR_W-1:0] if_pc_plus4,
    output logic [5:0]        if_opcode
);

    localparam logic [1:0] ST_RST   = 2'd0;
    localparam logic [1:0] ST_FETCH = 2'd1;
    localparam logic [1:0] ST_HOLD  = 2'd2;
    localparam logic [1:0] ST_KILL  = 2'd3;

    localparam logic [ADDR_W-1:0] PC_STEP    = ADDR_W'(4);
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(3);

    // Registered state
    logic [1:0]        r_state;
    logic [ADDR_W-1:0] r_pc;
    logic [ADDR_W-1:0] r_kill_addr;
    logic              r_valid;
    logic [31:0]       r_instr;
    logic [ADDR_W-1:0] r_slot_pc;
    logic [31:0]       r_hold_instr;
    logic [ADDR_W-1:0] r_hold_pc;

    // Next-state values
    logic [1:0]        w_state_nxt;
    logic [ADDR_W-1:0] w_pc_nxt;
    logic [ADDR_W-1:0] w_kill_addr_nxt;
    logic              w_valid_nxt;
    logic [31:0]       w_instr_nxt;
    logic [ADDR_W-1:0] w_slot_pc_nxt;
    logic [31:0]       w_hold_instr_nxt;
    logic [ADDR_W-1:0] w_hold_pc_nxt;

    // Helpers
    logic              w_slot_free;
    logic [ADDR_W-1:0] w_pc_plus4;
    logic [ADDR_W-1:0] w_target;

    // Decode drains the slot whenever it is not stalled; an empty slot is free too.
    assign w_slot_free = !r_valid || !stall;
    assign w_pc_plus4  = r_pc + PC_STEP;
    // Redirect targets are word aligned; low bits are dropped.
    assign w_target    = branch_target & ALIGN_MASK;

    // Next-state logic for the fetch FSM, PC, decode slot and hold buffer
    always_comb begin
        // NOTE: every next-state signal gets a default first so no path leaves one unassigned and infers a latch.
        w_state_nxt      = r_state;
        w_pc_nxt         = r_pc;
        w_kill_addr_nxt  = r_kill_addr;
        w_valid_nxt      = r_valid;
        w_instr_nxt      = r_instr;
        w_slot_pc_nxt    = r_slot_pc;
        w_hold_instr_nxt = r_hold_instr;
        w_hold_pc_nxt    = r_hold_pc;

        // A consumed slot empties unless a branch below refills it.
        if (w_slot_free) begin
            w_valid_nxt = 1'b0;
        end

        case (r_state)
            ST_RST: begin
                w_state_nxt = ST_FETCH;
            end

            ST_FETCH: begin
                if (branch_taken) begin
                    w_pc_nxt    = w_target;
                    w_valid_nxt = 1'b0;
                    if (!imem_ready) begin
                        // Response still owed for r_pc: remember it and swallow it later.
                        w_kill_addr_nxt = r_pc;
                        w_state_nxt     = ST_KILL;
                    end
                end else if (imem_ready) begin
                    w_pc_nxt = w_pc_plus4;
                    if (w_slot_free) begin
                        w_valid_nxt   = 1'b1;
                        w_instr_nxt   = imem_rdata;
                        w_slot_pc_nxt = r_pc;
                    end else begin
                        w_hold_instr_nxt = imem_rdata;
                        w_hold_pc_nxt    = r_pc;
                        w_state_nxt      = ST_HOLD;
                    end
                end
            end

            ST_HOLD: begin
                if (branch_taken) begin
                    w_pc_nxt         = w_target;
                    w_valid_nxt      = 1'b0;
                    w_hold_instr_nxt = '0;
                    w_hold_pc_nxt    = '0;
                    w_state_nxt      = ST_FETCH;
                end else if (w_slot_free) begin
                    w_valid_nxt   = 1'b1;
                    w_instr_nxt   = r_hold_instr;
                    w_slot_pc_nxt = r_hold_pc;
                    w_state_nxt   = ST_FETCH;
                end
            end

            ST_KILL: begin
                w_valid_nxt = 1'b0;
                // kill_addr is kept: the abandoned request is still the one on the bus.
                if (branch_taken) begin
                    w_pc_nxt = w_target;
                end
                if (imem_ready) begin
                    w_state_nxt = ST_FETCH;
                end
            end

            default: begin
                w_state_nxt = ST_RST;
            end
        endcase
    end

    // State registers with asynchronous reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_RST;
            r_pc         <= RESET_PC;
            r_kill_addr  <= '0;
            r_valid      <= 1'b0;
            r_instr      <= '0;
            r_slot_pc    <= '0;
            r_hold_instr <= '0;
            r_hold_pc    <= '0;
        end else begin
            // NOTE: state updates use non-blocking assignments so every register samples pre-edge values.
            r_state      <= w_state_nxt;
            r_pc         <= w_pc_nxt;
            r_kill_addr  <= w_kill_addr_nxt;
            r_valid      <= w_valid_nxt;
            r_instr      <= w_instr_nxt;
            r_slot_pc    <= w_slot_pc_nxt;
            r_hold_instr <= w_hold_instr_nxt;
            r_hold_pc    <= w_hold_pc_nxt;
        end
    end

    // Memory request depends only on registered state, never on ready or stall.
    assign imem_req  = (r_state == ST_FETCH) || (r_state == ST_KILL);
    assign imem_addr = (r_state == ST_KILL) ? r_kill_addr : r_pc;

    // Decode-facing outputs
    assign if_valid    = r_valid;
    assign if_instr    = r_instr;
    assign if_pc       = r_slot_pc;
    assign if_pc_plus4 = r_slot_pc + PC_STEP;
    assign if_opcode   = r_instr[31:26];

endmodule

// File: tb/tb_if_stage.sv
// Self-checking bench for if_stage: a memory responder with configurable wait
// states and a response budget, plus a scoreboard of expected decode-slot
// contents consumed whenever decode takes an instruction.
`timescale 1ns/1ps
module tb_if_stage;

    localparam int unsigned ADDR_W   = 32;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [5:0]  opcode;
        int          gap;     // required cycles since previous consumption, 0 = unchecked
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic        stall;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic [31:0] if_pc_plus4;
    logic [5:0]  if_opcode;

    int   n_tests;
    int   n_fail;
    exp_t sb_q[$];
    int   wait_cfg;
    int   resp_limit;
    int   resp_count;
    bit   force_ready;
    int   cyc;
    int   last_cyc;

    if_stage #(
        .ADDR_W   (ADDR_W),
        .RESET_PC (RESET_PC)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_ready    (imem_ready),
        .imem_rdata    (imem_rdata),
        .stall         (stall),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .if_valid      (if_valid),
        .if_instr      (if_instr),
        .if_pc         (if_pc),
        .if_pc_plus4   (if_pc_plus4),
        .if_opcode     (if_opcode)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        case (a)
            32'h0000_0000: return 32'h8000_0000;
            32'h0000_0004: return 32'h0400_0000;
            32'h0000_0008: return 32'h8400_0000;
            default:       return {a[7:2], a[27:2]};
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, got, exp);
        end
    endtask

    task automatic push_exp(input logic [31:0] pc, input int gap);
        exp_t e;
        e.pc     = pc;
        e.instr  = mem_word(pc);
        e.opcode = e.instr[31:26];
        e.gap    = gap;
        sb_q.push_back(e);
    endtask

    // Memory responder at negedge+2, slot monitor at negedge+4.
    task automatic run_bus();
        int          wait_cnt;
        logic [31:0] held_addr;
        exp_t        e;
        wait_cnt  = 0;
        held_addr = '0;
        forever begin
            @(negedge clk);
            #2;
            if (force_ready) begin
                imem_ready = 1'b1;
                imem_rdata = 32'hFFFF_FFFF;
                wait_cnt   = 0;
            end else if (imem_req) begin
                if (wait_cnt > 0) check("imem_addr_stable", imem_addr, held_addr);
                else held_addr = imem_addr;
                if (wait_cnt >= wait_cfg && resp_count < resp_limit) begin
                    imem_ready = 1'b1;
                    imem_rdata = mem_word(imem_addr);
                    resp_count++;
                    wait_cnt = 0;
                end else begin
                    imem_ready = 1'b0;
                    wait_cnt++;
                end
            end else begin
                imem_ready = 1'b0;
                wait_cnt   = 0;
            end
            #2;
            if (!rst && if_valid && !stall) begin
                if (sb_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_instr: got pc 0x%08h instr 0x%08h, expected none", if_pc, if_instr);
                end else begin
                    e = sb_q.pop_front();
                    check("if_pc", if_pc, e.pc);
                    check("if_instr", if_instr, e.instr);
                    check("if_opcode", 32'(if_opcode), 32'(e.opcode));
                    check("if_pc_plus4", if_pc_plus4, e.pc + 32'd4);
                    if (e.gap != 0) check("issue_gap", 32'(cyc - last_cyc), 32'(e.gap));
                end
                last_cyc = cyc;
            end
            cyc++;
        end
    endtask

    task automatic do_reset(input int wcfg, input int nresp);
        @(negedge clk);
        rst          = 1'b1;
        stall        = 1'b0;
        branch_taken = 1'b0;
        wait_cfg     = wcfg;
        repeat (2) @(negedge clk);
        rst        = 1'b0;
        resp_limit = resp_count + nresp;
    endtask

    task automatic wait_addr(input logic [31:0] a, input int limit);
        int n;
        n = 0;
        @(negedge clk);
        while (!(imem_req && imem_addr == a) && n < limit) begin
            @(negedge clk);
            n++;
        end
        check("wait_req", 32'(imem_req), 32'd1);
        check("wait_addr", imem_addr, a);
    endtask

    task automatic wait_slot(input logic [31:0] pc, input int limit);
        int n;
        n = 0;
        @(negedge clk);
        while (!(if_valid && if_pc == pc) && n < limit) begin
            @(negedge clk);
            n++;
        end
        check("wait_slot_pc", if_pc, pc);
    endtask

    task automatic drain(input int limit);
        int n;
        n = 0;
        while (sb_q.size() != 0 && n < limit) begin
            @(negedge clk);
            n++;
        end
        check("sb_drained", 32'(sb_q.size()), 32'd0);
        repeat (4) @(negedge clk);
    endtask

    initial begin
        exp_t startup_vec[3];
        n_tests       = 0;
        n_fail        = 0;
        rst           = 1'b1;
        stall         = 1'b0;
        branch_taken  = 1'b0;
        branch_target = '0;
        imem_ready    = 1'b0;
        imem_rdata    = '0;
        wait_cfg      = 0;
        resp_limit    = 0;
        resp_count    = 0;
        force_ready   = 1'b0;
        cyc           = 0;
        last_cyc      = 0;

        startup_vec[0] = '{pc: 32'h0, instr: 32'h8000_0000, opcode: 6'b100000, gap: 0};
        startup_vec[1] = '{pc: 32'h4, instr: 32'h0400_0000, opcode: 6'b000001, gap: 1};
        startup_vec[2] = '{pc: 32'h8, instr: 32'h8400_0000, opcode: 6'b100001, gap: 1};

        fork
            run_bus();
        join_none

        // Reset values
        @(negedge clk);
        #1;
        check("rst_imem_req", 32'(imem_req), 32'd0);
        check("rst_imem_addr", imem_addr, RESET_PC);
        check("rst_if_valid", 32'(if_valid), 32'd0);
        check("rst_if_instr", if_instr, 32'h0);
        check("rst_if_pc", if_pc, 32'h0);
        check("rst_if_pc_plus4", if_pc_plus4, 32'h4);
        check("rst_if_opcode", 32'(if_opcode), 32'd0);

        // Startup with zero-wait memory
        do_reset(0, 3);
        for (int i = 0; i < 3; i++) sb_q.push_back(startup_vec[i]);
        drain(20);

        // Two wait states per fetch
        do_reset(2, 3);
        for (int i = 0; i < 3; i++) push_exp(32'(4 * i), (i == 0) ? 0 : 3);
        drain(30);

        // Three-cycle stall while the slot holds pc 4
        do_reset(0, 4);
        push_exp(32'h0, 0);
        push_exp(32'h4, 4);
        push_exp(32'h8, 1);
        push_exp(32'hC, 1);
        wait_slot(32'h4, 10);
        for (int i = 0; i < 3; i++) begin
            if (i > 0) @(negedge clk);
            stall = 1'b1;
            #1;
            check("stall_slot_pc", if_pc, 32'h4);
            if (i > 0) check("stall_no_req", 32'(imem_req), 32'd0);
        end
        @(negedge clk);
        stall = 1'b0;
        drain(20);

        // Redirect while the fetch at 8 is waiting
        do_reset(2, 4);
        push_exp(32'h0, 0);
        push_exp(32'h4, 3);
        push_exp(32'h40, 6);
        wait_addr(32'h8, 20);
        branch_taken  = 1'b1;
        branch_target = 32'h43;
        @(negedge clk);
        branch_taken = 1'b0;
        #1;
        check("kill_req", 32'(imem_req), 32'd1);
        check("kill_addr_1", imem_addr, 32'h8);
        check("kill_valid", 32'(if_valid), 32'd0);
        @(negedge clk);
        #1;
        check("kill_addr_2", imem_addr, 32'h8);
        drain(30);

        // Redirect while stalled in HOLD
        do_reset(0, 4);
        push_exp(32'h0, 0);
        push_exp(32'h100, 4);
        wait_slot(32'h4, 10);
        stall = 1'b1;
        @(negedge clk);
        branch_taken  = 1'b1;
        branch_target = 32'h100;
        #1;
        check("hold_no_req", 32'(imem_req), 32'd0);
        @(negedge clk);
        branch_taken = 1'b0;
        stall        = 1'b0;
        #1;
        check("hold_redir_valid", 32'(if_valid), 32'd0);
        check("hold_redir_req", 32'(imem_req), 32'd1);
        check("hold_redir_addr", imem_addr, 32'h100);
        drain(20);

        // Redirect to the top word, PC wraps to 0
        do_reset(0, 0);
        @(negedge clk);
        branch_taken  = 1'b1;
        branch_target = 32'hFFFF_FFFE;
        push_exp(32'hFFFF_FFFC, 0);
        push_exp(32'h0, 1);
        @(negedge clk);
        branch_taken = 1'b0;
        resp_limit   = resp_count + 3;
        #1;
        check("wrap_kill_req", 32'(imem_req), 32'd1);
        check("wrap_kill_addr", imem_addr, 32'h0);
        drain(20);

        // Reset asserted while the fetch at 0x20 is pending
        do_reset(0, 8);
        for (int i = 0; i < 7; i++) push_exp(32'(4 * i), (i == 0) ? 0 : 1);
        wait_addr(32'h20, 30);
        check("pre_rst_valid", 32'(if_valid), 32'd1);
        rst         = 1'b1;
        force_ready = 1'b1;
        #1;
        check("midrst_req", 32'(imem_req), 32'd0);
        check("midrst_valid", 32'(if_valid), 32'd0);
        repeat (2) begin
            @(negedge clk);
            #1;
            check("rst_ignores_ready", 32'(if_valid), 32'd0);
        end
        @(negedge clk);
        rst        = 1'b0;
        resp_limit = resp_count + 1;
        @(negedge clk);
        force_ready = 1'b0;
        #1;
        check("post_rst_req", 32'(imem_req), 32'd1);
        check("post_rst_addr", imem_addr, RESET_PC);
        push_exp(RESET_PC, 0);
        drain(20);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
